// File: rtl/uint_serial_cmp_pkg.sv
// Shared definitions for the bit-serial unsigned comparator.
//   state_t : controller state encoding (IDLE/BUSY/DONE)
//   clog2   : ceiling log2, used to size the bit counter
package uint_serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uint_serial_cmp_bitstep.sv
// One comparison step: folds a single bit pair into the running lt/gt flags.
// A differing pair overwrites the flags, an equal pair keeps them, so when
// fed LSB-first the most significant difference wins.
//   i_a, i_b         : operand bits
//   i_lt, i_gt       : flags so far
//   o_lt, o_gt       : updated flags
module uint_serial_cmp_bitstep (
  input  logic i_a,
  input  logic i_b,
  input  logic i_lt,
  input  logic i_gt,
  output logic o_lt,
  output logic o_gt
);

  logic w_diff;

  assign w_diff = i_a ^ i_b;
  assign o_lt   = w_diff ? i_b : i_lt;
  assign o_gt   = w_diff ? i_a : i_gt;

endmodule

// File: rtl/uint_serial_cmp.sv
// Bit-serial unsigned magnitude comparator, LSB-first, one bit per cycle.
//   CLK, ASYNCRESET      : clock (rising) and async active-high reset
//   in_valid / in_ready  : operand handshake, I0 = A, I1 = B
//   out_valid / out_ready: result handshake
//   ult, ugt, eq         : A<B, A>B, A==B (meaningful while out_valid)
module uint_serial_cmp
  import uint_serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ult,
  output logic             ugt,
  output logic             eq
);

  localparam int unsigned    CW   = clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_gt;
  logic             w_lt_next;
  logic             w_gt_next;

  uint_serial_cmp_bitstep u_step (
    .i_a  (r_sh_a[0]),
    .i_b  (r_sh_b[0]),
    .i_lt (r_lt),
    .i_gt (r_gt),
    .o_lt (w_lt_next),
    .o_gt (w_gt_next)
  );

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_state_next = BUSY;
      BUSY:    if (r_cnt == LAST)   w_state_next = DONE;
      DONE:    if (out_ready)       w_state_next = IDLE;
      default:                      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_cnt  <= '0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh_a <= I0;
            r_sh_b <= I1;
            r_cnt  <= '0;
            r_lt   <= 1'b0;
            r_gt   <= 1'b0;
          end
        end
        BUSY: begin
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          r_cnt  <= r_cnt + CW'(1);
          r_lt   <= w_lt_next;
          r_gt   <= w_gt_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ult       = r_lt;
  assign ugt       = r_gt;
  assign eq        = ~(r_lt | r_gt);

endmodule

// File: tb/tb_uint_serial_cmp.sv
module tb_uint_serial_cmp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // WIDTH = 8 instance
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] i0 = '0, i1 = '0;
  logic       in_ready, out_valid, ult, ugt, eq;

  // WIDTH = 1 instance
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, ult1, ugt1, eq1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uint_serial_cmp #(.WIDTH(8)) dut8 (
    .CLK(clk), .ASYNCRESET(rst), .in_valid(in_valid), .in_ready(in_ready),
    .I0(i0), .I1(i1), .out_valid(out_valid), .out_ready(out_ready),
    .ult(ult), .ugt(ugt), .eq(eq)
  );

  uint_serial_cmp #(.WIDTH(1)) dut1 (
    .CLK(clk), .ASYNCRESET(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .I0(a1), .I1(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ult(ult1), .ugt(ugt1), .eq(eq1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the WIDTH=8 instance: an accepted pair yields
  // {A<B, A>B, A==B} exactly WIDTH edges later, held until retired.
  bit         m_busy = 0, m_valid = 0;
  int         m_left = 0;
  logic [2:0] m_res  = '0;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         acc_cyc[$];
  logic [2:0] res_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 0;
      m_valid = 0;
    end else begin
      cyc++;
      if (m_valid) begin
        if (out_ready) begin
          res_q.push_back({ult, ugt, eq});
          m_valid = 0;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          m_valid = 1;
        end
      end else if (in_valid) begin
        m_res  = {i0 < i1, i0 > i1, i0 == i1};
        m_busy = 1;
        m_left = 8;
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_in_ready", in_ready, !m_busy && !m_valid);
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_result", {ult, ugt, eq}, m_res);
        chk("ult_ugt_exclusive", ult & ugt, 1'b0);
      end
    end
  end

  task automatic do_cmp8(input logic [7:0] a, input logic [7:0] b,
                         input int hold, input logic [2:0] exp, input string nm);
    int lat;
    out_ready = 1'b0;
    lat = 0;
    while (!in_ready && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, "_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1; i0 = a; i1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    i0 = 8'($urandom); i1 = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({nm, "_ready_busy"}, in_ready, 1'b0);
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_result"}, {ult, ugt, eq}, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, out_valid, 1'b1);
      chk({nm, "_hold_ready"}, in_ready, 1'b0);
      chk({nm, "_hold_result"}, {ult, ugt, eq}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_retired_valid"}, out_valid, 1'b0);
    chk({nm, "_retired_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic [2:0] pexp[3];
    int guard;

    #12;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_flags", {ult, ugt, eq}, 3'b001);
    chk("reset_w1_ready", in_ready1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_cmp8(8'd3,   8'd5,   0, 3'b100, "lt_3_5");
    do_cmp8(8'h80,  8'h7F,  0, 3'b010, "msb_wins");
    do_cmp8(8'd200, 8'd200, 5, 3'b001, "eq_hold");

    // Back-to-back with a constantly ready consumer.
    pa = '{8'd0, 8'd255, 8'd0};
    pb = '{8'd255, 8'd0, 8'd0};
    pexp = '{3'b100, 3'b010, 3'b001};
    res_q.delete();
    acc_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int start;
      start = acc_cnt;
      in_valid = 1'b1; i0 = pa[i]; i1 = pb[i];
      guard = 0;
      while (acc_cnt == start && guard < 30) begin @(posedge clk); #1; guard++; end
      chk("b2b_accept_timeout", guard < 30, 1'b1);
    end
    in_valid = 1'b0;
    guard = 0;
    while (res_q.size() < 3 && guard < 40) begin @(posedge clk); #1; guard++; end
    chk("b2b_result_count", res_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < res_q.size()) chk("b2b_result", res_q[i], pexp[i]);
    if (acc_cyc.size() == 3) begin
      chk("b2b_spacing0", acc_cyc[1] - acc_cyc[0], 10);
      chk("b2b_spacing1", acc_cyc[2] - acc_cyc[1], 10);
    end

    // Abort after three shifts with an asynchronous reset pulse.
    in_valid = 1'b1; i0 = 8'd9; i1 = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_flags", {ult, ugt, eq}, 3'b001);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_cmp8(8'd1, 8'd2, 0, 3'b100, "after_abort");

    // WIDTH = 1, all four operand pairs.
    out_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [0:0] a, b;
      a = 1'(k >> 1);
      b = 1'(k);
      in_valid1 = 1'b1; a1 = a; b1 = b;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      chk("w1_busy_valid", out_valid1, 1'b0);
      chk("w1_busy_ready", in_ready1, 1'b0);
      @(posedge clk); #1;
      chk("w1_done_valid", out_valid1, 1'b1);
      chk("w1_result", {ult1, ugt1, eq1}, {a < b, a > b, a == b});
      @(posedge clk); #1;
      chk("w1_idle_ready", in_ready1, 1'b1);
    end
    chk("w1_pin_last", {ult1, ugt1, eq1}, 3'b001);

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: begin i0 = 8'($urandom); i1 = i0; end
        1: begin i0 = 8'($urandom); i1 = i0 ^ (8'd1 << $urandom_range(0, 7)); end
        default: begin i0 = 8'($urandom); i1 = 8'($urandom); end
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("final_idle", in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
